// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single data-memory port between the core (C)
// and the debug/loader port (D); one access in flight at a time.
module dmem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant,
  output logic              busy
);

  localparam int CNT_W = $clog2(MEM_LAT) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_reg;
  logic                last_grant_reg;
  logic                we_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                grant_reg;
  logic                busy_reg;
  logic                c_ack_reg;
  logic                d_ack_reg;
  logic                mem_read_reg;
  logic                mem_write_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [DATA_W-1:0]   mem_wdata_reg;
  logic [DATA_W-1:0]   c_rdata_reg;
  logic [DATA_W-1:0]   d_rdata_reg;

  logic any_req;
  logic pick_d;
  logic sel_we;

  // On a tie the port that did not win last time gets the memory.
  assign any_req = c_req | d_req;
  assign pick_d  = d_req & (~c_req | ~last_grant_reg);
  assign sel_we  = pick_d ? d_we : c_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      we_reg         <= 1'b0;
      cnt_reg        <= '0;
      grant_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      c_ack_reg      <= 1'b0;
      d_ack_reg      <= 1'b0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      c_rdata_reg    <= '0;
      d_rdata_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          c_ack_reg <= 1'b0;
          d_ack_reg <= 1'b0;
          if (any_req) begin
            grant_reg      <= pick_d;
            last_grant_reg <= pick_d;
            we_reg         <= sel_we;
            mem_addr_reg   <= pick_d ? d_addr : c_addr;
            mem_wdata_reg  <= pick_d ? d_wdata : c_wdata;
            mem_read_reg   <= ~sel_we;
            mem_write_reg  <= sel_we;
            cnt_reg        <= CNT_W'(MEM_LAT - 1);
            busy_reg       <= 1'b1;
            state_reg      <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_reg == '0) begin
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            if (!we_reg) begin
              if (grant_reg) d_rdata_reg <= mem_rdata;
              else           c_rdata_reg <= mem_rdata;
            end
            c_ack_reg <= ~grant_reg;
            d_ack_reg <= grant_reg;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        DONE: begin
          c_ack_reg <= 1'b0;
          d_ack_reg <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign c_ack     = c_ack_reg;
  assign d_ack     = d_ack_reg;
  assign c_rdata   = c_rdata_reg;
  assign d_rdata   = d_rdata_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_read  = mem_read_reg;
  assign mem_write = mem_write_reg;
  assign grant     = grant_reg;
  assign busy      = busy_reg;

endmodule
